// File: rtl/eprisc_bus_decoder_pkg.sv
// eprisc_bus_pkg: FSM states, fault codes and width helper shared by the bus decoder files.
package eprisc_bus_pkg;
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
   typedef enum logic [1:0] {
      FAULT_NONE     = 2'd0,
      FAULT_UNMAPPED = 2'd1,
      FAULT_TIMEOUT  = 2'd2
   } fault_t;
   function automatic int clog2_min1(input int v);
      return (v < 2) ? 1 : $clog2(v);
   endfunction
endpackage

// File: rtl/eprisc_bus_decoder_if.sv
// eprisc_bus_decoder_if: core request, slave completion and fault-record signals of the decoder.
interface eprisc_bus_decoder_if #(
   parameter int CHANNELS   = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                           iAccess;
   logic                           iWrite;
   logic [ADDR_WIDTH-1:0]          iAddress;
   logic [CHANNELS-1:0]            iSlaveReady;
   logic [CHANNELS*DATA_WIDTH-1:0] iSlaveData;
   logic                           iFaultClear;
   logic [CHANNELS-1:0]            oSelect;
   logic                           oWrite;
   logic                           oReady;
   logic [DATA_WIDTH-1:0]          oData;
   logic                           oError;
   logic                           oFault;
   logic [1:0]                     oFaultCode;
   logic [ADDR_WIDTH-1:0]          oFaultAddress;
   modport master (
      output iAccess, iWrite, iAddress, iSlaveReady, iSlaveData, iFaultClear,
      input  oSelect, oWrite, oReady, oData, oError, oFault, oFaultCode, oFaultAddress
   );
   modport slave (
      input  iAccess, iWrite, iAddress, iSlaveReady, iSlaveData, iFaultClear,
      output oSelect, oWrite, oReady, oData, oError, oFault, oFaultCode, oFaultAddress
   );
endinterface

// File: rtl/eprisc_bus_decoder_region_match.sv
// eprisc_region_match: combinational address-window matcher, lowest hitting index wins.
module eprisc_region_match
   import eprisc_bus_pkg::*;
#(
   parameter int CHANNELS   = 4,
   parameter int ADDR_WIDTH = 32,
   parameter logic [CHANNELS*ADDR_WIDTH-1:0] CH_BASE  = '0,
   parameter logic [CHANNELS*ADDR_WIDTH-1:0] CH_LIMIT = '0,
   localparam int IW = clog2_min1(CHANNELS)
) (
   input  logic [ADDR_WIDTH-1:0] addr,
   output logic                  hit,
   output logic [IW-1:0]         index
);
   // Scanning downwards lets the lowest matching window overwrite the rest.
   always_comb begin
      hit   = 1'b0;
      index = '0;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         if (addr >= CH_BASE[i*ADDR_WIDTH +: ADDR_WIDTH] && addr < CH_LIMIT[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
            hit   = 1'b1;
            index = IW'(i);
         end
      end
   end
endmodule

// File: rtl/eprisc_bus_decoder.sv
// eprisc_bus_decoder: windowed slave select with registered Access/Ready handshake,
// bus timeout and a sticky fault record.
module eprisc_bus_decoder
   import eprisc_bus_pkg::*;
#(
   parameter int CHANNELS   = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter logic [CHANNELS*ADDR_WIDTH-1:0] CH_BASE  = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000},
   parameter logic [CHANNELS*ADDR_WIDTH-1:0] CH_LIMIT = {32'h0080_0000, 32'h0000_3000, 32'h0000_2000, 32'h0000_1000},
   parameter int TIMEOUT    = 16
) (
   input logic                  iClock,
   input logic                  iReset,
   eprisc_bus_decoder_if.slave  bus
);
   localparam int IW = clog2_min1(CHANNELS);
   localparam int CW = clog2_min1(TIMEOUT + 1);

   state_t                state_q;
   logic [IW-1:0]         idx_q;
   logic [CW-1:0]         cnt_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [CHANNELS-1:0]   select_q;
   logic                  write_q;
   logic                  ready_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  error_q;
   logic                  fault_q;
   fault_t                fcode_q;
   logic [ADDR_WIDTH-1:0] faddr_q;
   logic                  m_hit;
   logic [IW-1:0]         m_index;

   eprisc_region_match #(
      .CHANNELS  (CHANNELS),
      .ADDR_WIDTH(ADDR_WIDTH),
      .CH_BASE   (CH_BASE),
      .CH_LIMIT  (CH_LIMIT)
   ) u_match (
      .addr (bus.iAddress),
      .hit  (m_hit),
      .index(m_index)
   );

   // A fault raised later in this block overrides a same-cycle clear.
   always_ff @(posedge iClock) begin
      if (iReset) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         cnt_q    <= '0;
         addr_q   <= '0;
         select_q <= '0;
         write_q  <= 1'b0;
         ready_q  <= 1'b0;
         data_q   <= '0;
         error_q  <= 1'b0;
         fault_q  <= 1'b0;
         fcode_q  <= FAULT_NONE;
         faddr_q  <= '0;
      end else begin
         if (bus.iFaultClear) begin
            fault_q <= 1'b0;
            fcode_q <= FAULT_NONE;
            faddr_q <= '0;
         end
         case (state_q)
            S_IDLE: if (bus.iAccess) begin
               addr_q  <= bus.iAddress;
               write_q <= bus.iWrite;
               idx_q   <= m_index;
               cnt_q   <= '0;
               if (m_hit) begin
                  state_q  <= S_WAIT;
                  select_q <= CHANNELS'(1) << m_index;
               end else begin
                  state_q <= S_DONE;
                  ready_q <= 1'b1;
                  data_q  <= '0;
                  error_q <= 1'b1;
                  fault_q <= 1'b1;
                  fcode_q <= FAULT_UNMAPPED;
                  faddr_q <= bus.iAddress;
               end
            end
            S_WAIT: if (!bus.iAccess) begin
               state_q  <= S_IDLE;
               select_q <= '0;
            end else if (bus.iSlaveReady[idx_q]) begin
               state_q  <= S_DONE;
               select_q <= '0;
               ready_q  <= 1'b1;
               data_q   <= bus.iSlaveData[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];
               error_q  <= 1'b0;
            end else if (TIMEOUT != 0 && cnt_q == CW'(TIMEOUT - 1)) begin
               state_q  <= S_DONE;
               select_q <= '0;
               ready_q  <= 1'b1;
               data_q   <= '0;
               error_q  <= 1'b1;
               fault_q  <= 1'b1;
               fcode_q  <= FAULT_TIMEOUT;
               faddr_q  <= addr_q;
            end else begin
               cnt_q <= cnt_q + CW'(1);
            end
            S_DONE: if (!bus.iAccess) begin
               state_q <= S_IDLE;
               ready_q <= 1'b0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.oSelect       = select_q;
   assign bus.oWrite        = write_q;
   assign bus.oReady        = ready_q;
   assign bus.oData         = data_q;
   assign bus.oError        = error_q;
   assign bus.oFault        = fault_q;
   assign bus.oFaultCode    = fcode_q;
   assign bus.oFaultAddress = faddr_q;
endmodule
